// File: rtl/branch_wb_unit_if.sv
// Instruction, ALU, redirect/trap and writeback signals shared between a core front-end
// and the branch/writeback unit.
interface branch_wb_unit_if #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned WB_DEPTH = 2
);
   localparam int unsigned CNT_W = $clog2(WB_DEPTH) + 1;

   logic             instr_valid;
   logic             instr_ready;
   logic [3:0]       br_op;
   logic [XLEN-1:0]  pc;
   logic [XLEN-1:0]  rs1_value;
   logic [XLEN-1:0]  rs2_value;
   logic [XLEN-1:0]  imm;
   logic             rd_en;
   logic [4:0]       rd_addr;
   logic [XLEN-1:0]  alu_result;
   logic             alu_ready;
   logic             redirect_valid;
   logic [XLEN-1:0]  redirect_pc;
   logic             misalign_trap;
   logic [XLEN-1:0]  trap_pc;
   logic             wb_valid;
   logic             wb_ready;
   logic [4:0]       wb_addr;
   logic [XLEN-1:0]  wb_data;
   logic [CNT_W-1:0] wb_count;

   modport master (
      output instr_valid, br_op, pc, rs1_value, rs2_value, imm, rd_en, rd_addr,
             alu_result, alu_ready, wb_ready,
      input  instr_ready, redirect_valid, redirect_pc, misalign_trap, trap_pc,
             wb_valid, wb_addr, wb_data, wb_count
   );

   modport slave (
      input  instr_valid, br_op, pc, rs1_value, rs2_value, imm, rd_en, rd_addr,
             alu_result, alu_ready, wb_ready,
      output instr_ready, redirect_valid, redirect_pc, misalign_trap, trap_pc,
             wb_valid, wb_addr, wb_data, wb_count
   );
endinterface

// File: rtl/branch_wb_unit.sv
// Resolves branches/jumps into redirect or misalign-trap pulses and queues link/ALU results
// in a small writeback FIFO.
module branch_wb_unit #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned WB_DEPTH   = 2,
   parameter int unsigned ALIGN_BITS = 2
) (
   input logic              clk,
   input logic              rst_n,
   branch_wb_unit_if.slave  bus
);
   localparam int unsigned PTR_W = $clog2(WB_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [0:0] {StIdle, StWaitAlu} state_e;

   state_e           state_q;
   logic [4:0]       rd_q;
   logic             redirect_valid_q;
   logic [XLEN-1:0]  redirect_pc_q;
   logic             misalign_trap_q;
   logic [XLEN-1:0]  trap_pc_q;

   logic [4:0]       addr_mem [WB_DEPTH];
   logic [XLEN-1:0]  data_mem [WB_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;

   logic             accept;
   logic             taken;
   logic             is_jump;
   logic             aligned;
   logic [XLEN-1:0]  target;
   logic             push;
   logic             pop;
   logic             alu_push;
   logic [4:0]       push_addr;
   logic [XLEN-1:0]  push_data;
   logic             wb_valid;

   assign bus.instr_ready = (state_q == StIdle) && (count_q < CNT_W'(WB_DEPTH));
   assign accept          = bus.instr_valid && bus.instr_ready;

   always_comb begin
      taken   = 1'b0;
      is_jump = 1'b0;
      target  = bus.pc + bus.imm;
      case (bus.br_op)
         4'd1: taken = (bus.rs1_value == bus.rs2_value);
         4'd2: taken = (bus.rs1_value != bus.rs2_value);
         4'd3: taken = ($signed(bus.rs1_value) <  $signed(bus.rs2_value));
         4'd4: taken = ($signed(bus.rs1_value) >= $signed(bus.rs2_value));
         4'd5: taken = (bus.rs1_value <  bus.rs2_value);
         4'd6: taken = (bus.rs1_value >= bus.rs2_value);
         4'd7: begin
            taken   = 1'b1;
            is_jump = 1'b1;
         end
         4'd8: begin
            taken   = 1'b1;
            is_jump = 1'b1;
            target  = (bus.rs1_value + bus.imm) & ~XLEN'(1);
         end
         default: ;
      endcase
      aligned = (target[ALIGN_BITS-1:0] == '0);
   end

   // Link writes are suppressed when the jump traps.
   always_comb begin
      alu_push  = (state_q == StWaitAlu) && bus.alu_ready;
      push      = alu_push ||
                  (accept && is_jump && aligned && bus.rd_en && (bus.rd_addr != 5'd0));
      push_addr = alu_push ? rd_q : bus.rd_addr;
      push_data = alu_push ? bus.alu_result : bus.pc + XLEN'(4);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= StIdle;
         rd_q             <= 5'd0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         misalign_trap_q  <= 1'b0;
         trap_pc_q        <= '0;
      end else begin
         redirect_valid_q <= accept && taken && aligned;
         misalign_trap_q  <= accept && taken && !aligned;
         if (accept && taken && aligned) redirect_pc_q <= target;
         if (accept && taken && !aligned) trap_pc_q <= bus.pc;
         case (state_q)
            StIdle: begin
               if (accept && (bus.br_op == 4'd0) && bus.rd_en && (bus.rd_addr != 5'd0)) begin
                  rd_q    <= bus.rd_addr;
                  state_q <= StWaitAlu;
               end
            end
            StWaitAlu: begin
               if (bus.alu_ready) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign wb_valid = (count_q != '0);
   assign pop      = wb_valid && bus.wb_ready;

   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr_q] <= push_addr;
         data_mem[wr_ptr_q] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: ;
         endcase
      end
   end

   assign bus.redirect_valid = redirect_valid_q;
   assign bus.redirect_pc    = redirect_pc_q;
   assign bus.misalign_trap  = misalign_trap_q;
   assign bus.trap_pc        = trap_pc_q;
   assign bus.wb_valid       = wb_valid;
   assign bus.wb_count       = count_q;
   // Gate the head so stale entries never show on the bus while empty or in reset.
   assign bus.wb_addr        = wb_valid ? addr_mem[rd_ptr_q] : 5'd0;
   assign bus.wb_data        = wb_valid ? data_mem[rd_ptr_q] : '0;
endmodule
